// File: rtl/pll_pkg.sv
// pll_pkg: shared types, default timing constants and small helpers for the
// PLL lock monitor. The optional timeout/retry path is selected by the
// PLL_LOCK_RETRY_EN macro in pll_lock_monitor.
package pll_pkg;

    // Monitor states; PLL_RST is only reachable when the retry path is built.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_PLL_RST   = 2'd3
    } pll_state_e;

    // Defaults assume a 12 MHz reference clock.
    localparam int unsigned DEF_STABLE_CYCLES  = 4096;    // ~341 us
    localparam int unsigned DEF_TIMEOUT_CYCLES = 120000;  // 10 ms
    localparam int unsigned DEF_RESETB_CYCLES  = 12;

    localparam logic [7:0] STAT_MAX = 8'hFF;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == STAT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: qualifies the PLL LOCK signal, releases the downstream
// reset once lock has been stable long enough, and counts lock losses.
// Define PLL_LOCK_RETRY_EN to build the lock timeout that pulses the PLL
// RESETB pin and counts retries; without it WAIT_LOCK waits forever.
module pll_lock_monitor
    import pll_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned RESETB_CYCLES  = DEF_RESETB_CYCLES
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       clear_stats,
    output logic       pll_resetb,
    output logic       sys_reset_n,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic [7:0] retry_count
);

    // One counter is shared by all timed states, so size it for the longest.
    localparam int unsigned MAX_CYCLES = max3(STABLE_CYCLES, TIMEOUT_CYCLES, RESETB_CYCLES);
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             lock_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             loss_inc;
    logic [7:0]       loss_q, loss_d;
    logic             ready_q;
    logic             sys_reset_n_q;

`ifdef PLL_LOCK_RETRY_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESETB_LAST  = CNT_W'(RESETB_CYCLES - 1);

    logic       retry_inc;
    logic [7:0] retry_q, retry_d;
    logic       pll_resetb_q;
`endif

    sync_2ff u_lock_sync (
        .clk_i  (clock_in),
        .rst_ni (reset_n),
        .d_i    (locked),
        .q_o    (lock_s)
    );

    // Next-state and shared-counter logic for the qualification FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_inc = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
        retry_inc = 1'b0;
`endif
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
`ifdef PLL_LOCK_RETRY_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_STABLE: begin
                // A drop before qualification is not a loss: never reached RUN.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT_LOCK;
                    cnt_d    = '0;
                    loss_inc = 1'b1;
                end
            end
`ifdef PLL_LOCK_RETRY_EN
            ST_PLL_RST: begin
                // lock_s is ignored here: the PLL is being held in reset.
                if (cnt_q == RESETB_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loss statistic: a clear in the same cycle wins over the increment.
    always_comb begin
        loss_d = loss_q;
        if (clear_stats) begin
            loss_d = '0;
        end else if (loss_inc) begin
            loss_d = sat_inc(loss_q);
        end
    end

    // Loss counter register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    // Outputs registered from next state so they line up with state==RUN.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            ready_q       <= 1'b0;
            sys_reset_n_q <= 1'b0;
        end else begin
            ready_q       <= (state_d == ST_RUN);
            sys_reset_n_q <= (state_d == ST_RUN);
        end
    end

`ifdef PLL_LOCK_RETRY_EN
    // Retry statistic: a clear in the same cycle wins over the increment.
    always_comb begin
        retry_d = retry_q;
        if (clear_stats) begin
            retry_d = '0;
        end else if (retry_inc) begin
            retry_d = sat_inc(retry_q);
        end
    end

    // Retry counter and PLL reset pin registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            retry_q      <= '0;
            pll_resetb_q <= 1'b1;
        end else begin
            retry_q      <= retry_d;
            pll_resetb_q <= (state_d != ST_PLL_RST);
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign retry_count = retry_q;
`else
    assign pll_resetb  = 1'b1;
    assign retry_count = 8'd0;
`endif

    assign ready       = ready_q;
    assign sys_reset_n = sys_reset_n_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: randomized and directed checks of pll_lock_monitor
// against a streak-based behavioural model. Honours PLL_LOCK_RETRY_EN.
module tb_pll_lock_monitor;

    localparam int SC = 8;
    localparam int TC = 32;
    localparam int RC = 4;
`ifdef PLL_LOCK_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       clock_in    = 1'b0;
    logic       reset_n     = 1'b0;
    logic       locked      = 1'b0;
    logic       clear_stats = 1'b0;
    logic       pll_resetb;
    logic       sys_reset_n;
    logic       ready;
    logic [7:0] loss_count;
    logic [7:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pll_lock_monitor #(
        .STABLE_CYCLES  (SC),
        .TIMEOUT_CYCLES (TC),
        .RESETB_CYCLES  (RC)
    ) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .locked      (locked),
        .clear_stats (clear_stats),
        .pll_resetb  (pll_resetb),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .loss_count  (loss_count),
        .retry_count (retry_count)
    );

    initial forever #5 clock_in = ~clock_in;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ready means "at least SC+1 consecutive lock samples";
    // a timeout is TC consecutive no-lock samples starting from a quiet wait.
    bit lk_d1, lk_d2, m_s;
    int streak, idle, rst_left, m_loss, m_retry;
    bit loss_ev, retry_ev;

    initial forever begin
        @(posedge clock_in or negedge reset_n);
        if (!reset_n) begin
            lk_d1 = 0; lk_d2 = 0; streak = 0; idle = 0; rst_left = 0;
            m_loss = 0; m_retry = 0;
        end else begin
            m_s = lk_d2; lk_d2 = lk_d1; lk_d1 = locked;
            loss_ev = 0; retry_ev = 0;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) retry_ev = 1;
            end else if (m_s) begin
                if (streak < SC + 1) streak++;
                idle = 0;
            end else begin
                if (streak >= SC + 1) loss_ev = 1;
                if (streak == 0) idle++;
                else idle = 0;
                streak = 0;
                if (RETRY_EN && idle == TC) begin
                    rst_left = RC;
                    idle = 0;
                end
            end
            if (clear_stats) begin
                m_loss = 0; m_retry = 0;
            end else begin
                if (loss_ev && m_loss < 255) m_loss++;
                if (retry_ev && m_retry < 255) m_retry++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clock_in);
        if (chk_en && reset_n) begin
            check("cyc_ready", ready, (rst_left == 0 && streak >= SC + 1));
            check("cyc_sys_reset_n", sys_reset_n, (rst_left == 0 && streak >= SC + 1));
            check("cyc_pll_resetb", pll_resetb, (rst_left == 0));
            check("cyc_loss_count", loss_count, m_loss);
            check("cyc_retry_count", retry_count, m_retry);
        end
    end

    task automatic wait_ready(input logic lvl, input int max, output int k);
        k = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clock_in); #1;
            if (ready === lvl) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock_in);
        reset_n = 1'b0;
        locked  = 1'b0;
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    initial begin
        int k, k0, t, first_low, w, seen;

        // Reset state
        repeat (3) @(negedge clock_in);
        check("rst_sys_reset_n", sys_reset_n, 0);
        check("rst_ready", ready, 0);
        check("rst_pll_resetb", pll_resetb, 1);
        check("rst_loss_count", loss_count, 0);
        check("rst_retry_count", retry_count, 0);
        $display("[TB] reset state checked");
        chk_en = 1'b1;

        // Nominal start: locked rises 5 cycles after release
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (5) @(negedge clock_in);
        locked = 1'b1;
        wait_ready(1'b1, 40, k);
        check("nominal_latency", k, 11);
        check("nominal_sys_reset_n", sys_reset_n, 1);
        check("nominal_loss", loss_count, 0);
        $display("[TB] nominal start: ready after %0d cycles", k);

        // Lock loss: one-cycle drop in RUN
        @(negedge clock_in);
        locked = 1'b0;
        @(posedge clock_in); #1;
        check("loss_ready_e0", ready, 1);
        @(negedge clock_in);
        locked = 1'b1;
        @(posedge clock_in); #1;
        check("loss_ready_e1", ready, 1);
        @(posedge clock_in); #1;
        check("loss_ready_e2", ready, 0);
        check("loss_count_1", loss_count, 1);
        wait_ready(1'b1, 20, k);
        check("loss_requalify", k, 9);
        $display("[TB] lock loss: loss_count=%0d requalified after %0d cycles", loss_count, k);

        // Glitch rejection: 3 cycles of lock
        do_reset();
        repeat (2) @(negedge clock_in);
        locked = 1'b1;
        repeat (3) @(negedge clock_in);
        locked = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock_in); #1;
            if (ready !== 1'b0) seen++;
        end
        check("glitch_ready_seen", seen, 0);
        check("glitch_loss", loss_count, 0);
        $display("[TB] glitch rejection: ready high cycles=%0d", seen);

`ifdef PLL_LOCK_RETRY_EN
        // Timeout: locked stays low from reset release
        do_reset();
        t = 0; first_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock_in); #1; t++;
            if (pll_resetb === 1'b0) begin
                first_low = t;
                break;
            end
        end
        check("timeout_first_low", first_low, TC);
        w = (first_low != 0) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_in); #1; t++;
            if (pll_resetb === 1'b0) w++;
            else break;
        end
        check("timeout_width", w, RC);
        check("timeout_retry_1", retry_count, 1);
        k0 = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock_in); #1; t++;
            if (pll_resetb === 1'b0) begin
                k0 = t;
                break;
            end
        end
        check("timeout_period", k0 - first_low, TC + RC);
        $display("[TB] timeout: first pulse at %0d width %0d next at %0d", first_low, w, k0);
`else
        // No retry build: WAIT_LOCK waits forever
        do_reset();
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock_in); #1;
            if (pll_resetb !== 1'b1) seen++;
        end
        check("noretry_resetb_low", seen, 0);
        check("noretry_retry_count", retry_count, 0);
        $display("[TB] no-retry build: pll_resetb low cycles=%0d", seen);
`endif

        // Saturation: 259 losses, then a loss coinciding with clear_stats
        do_reset();
        locked = 1'b1;
        wait_ready(1'b1, 30, k);
        check("sat_first_run", (k > 0), 1);
        for (int n = 0; n < 259; n++) begin
            @(negedge clock_in);
            locked = 1'b0;
            @(negedge clock_in);
            locked = 1'b1;
            wait_ready(1'b0, 5, k0);
            wait_ready(1'b1, 20, k);
            check("sat_cycle", ((k0 > 0) && (k > 0)), 1);
        end
        check("sat_loss_255", loss_count, 255);
        @(negedge clock_in);
        locked = 1'b0;
        @(negedge clock_in);
        locked = 1'b1;
        @(negedge clock_in);
        clear_stats = 1'b1;
        @(negedge clock_in);
        clear_stats = 1'b0;
        check("clear_loss_0", loss_count, 0);
        check("clear_ready_0", ready, 0);
        $display("[TB] saturation and clear done");

        // Randomized lock activity with occasional clears
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            len = (seg % 2 == 0) ? int'($urandom_range(1, 20))
                                 : int'($urandom_range(1, RETRY_EN ? 45 : 8));
            for (int c = 0; c < len; c++) begin
                @(negedge clock_in);
                if (c == 0) locked = (seg % 2 == 0);
                clear_stats = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clock_in);
        clear_stats = 1'b0;
        $display("[TB] random phase done, loss_count=%0d retry_count=%0d", loss_count, retry_count);

        // Reset mid-RUN, asserted between clock edges
        locked = 1'b1;
        wait_ready(1'b1, 60, k);
        check("midrun_reach_run", ready, 1);
        @(negedge clock_in);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_sys_reset_n", sys_reset_n, 0);
        check("midrun_ready", ready, 0);
        check("midrun_loss", loss_count, 0);
        check("midrun_retry", retry_count, 0);
        check("midrun_pll_resetb", pll_resetb, 1);
        $display("[TB] reset mid-RUN checked");
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (5) @(negedge clock_in);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4096; consecutive synced-lock cycles required before release (~341 us at 12 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 120000; cycles allowed in WAIT_LOCK before a PLL reset retry (10 ms).
REQ-003 SHALL have parameter RESETB_CYCLES, default 12; width of the PLL reset pulse in cycles.
REQ-004 SHALL have port clock_in, input, 1; 12 MHz reference clock, also the PLL REFERENCECLK; the single clock of this block.
REQ-005 SHALL have port reset_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port locked, input, 1; PLL LOCK, asynchronous to clock_in.
REQ-007 SHALL have port clear_stats, input, 1; synchronous single-cycle pulse that zeroes the counters.
REQ-008 SHALL have port pll_resetb, output, 1; drives the PLL RESETB pin, active-low.
REQ-009 SHALL have port sys_reset_n, output, 1; active-low reset request to downstream logic (the consumer re-synchronises it into the PLL domain).
REQ-010 SHALL have port ready, output, 1; high while the PLL is qualified stable.
REQ-011 SHALL have port loss_count, output, 8; lock-loss events seen in RUN, saturating.
REQ-012 SHALL have port retry_count, output, 8; PLL reset retries issued, saturating.

Function
REQ-013 SHALL pass locked through a 2-flop synchronizer giving lock_s; locked edge to lock_s change takes 2 clock_in cycles.
REQ-014 SHALL implement states WAIT_LOCK, STABLE, RUN and PLL_RST, with one shared cycle counter cnt of width $clog2(max parameter).
REQ-015 SHALL, in WAIT_LOCK: move to STABLE with cnt=0 if lock_s=1; else increment cnt, and at cnt==TIMEOUT_CYCLES-1 go to PLL_RST with cnt=0.
REQ-016 SHALL, in STABLE: return to WAIT_LOCK with cnt=0 if lock_s=0, without counting a loss; else go to RUN at cnt==STABLE_CYCLES-1.
REQ-017 SHALL, in RUN: go to WAIT_LOCK with cnt=0 on lock_s=0 and increment loss_count, saturating at 255.
REQ-018 SHALL, in PLL_RST: hold pll_resetb=0 for exactly RESETB_CYCLES cycles, then go to WAIT_LOCK with cnt=0 and increment retry_count, saturating at 255.
REQ-019 SHALL make sys_reset_n and ready registered from next-state, so each is high in exactly the cycles where state==RUN.
REQ-020 SHALL make pll_resetb registered, low in exactly the PLL_RST cycles.
REQ-021 SHALL give clear_stats priority over a same-cycle increment; both counters read 0 the next cycle.
REQ-022 SHALL keep lock_s activity during PLL_RST from affecting the state or the counters.

Reset
REQ-023 SHALL, while reset_n=0, force: state=WAIT_LOCK, cnt=0, synchronizer flops=0, sys_reset_n=0, ready=0, pll_resetb=1, loss_count=0, retry_count=0.
REQ-024 SHALL, on reset asserted mid-operation (any state), force sys_reset_n=0 immediately and asynchronously.

Configuration
REQ-025 SHALL use the macro PLL_LOCK_RETRY_EN to control the timeout/retry feature.
REQ-026 SHALL, with PLL_LOCK_RETRY_EN defined, implement the timeout/retry behaviour of REQ-015/018.
REQ-027 SHALL, without PLL_LOCK_RETRY_EN: not instantiate PLL_RST; WAIT_LOCK waits indefinitely; pll_resetb is tied to 1; retry_count is tied to 0.

Structure
REQ-028 SHALL place the state enum typedef and the default parameter constants in the shared package pll_pkg.
REQ-029 SHALL implement the synchronizer as sub-module sync_2ff, 1 bit wide, asynchronous active-low reset.

Verification (STABLE_CYCLES=8, TIMEOUT_CYCLES=32, RESETB_CYCLES=4)
REQ-030 SHALL verify nominal start: locked rises 5 cycles after reset release -> ready and sys_reset_n rise 2+1+8 cycles later; loss_count=0.
REQ-031 SHALL verify glitch rejection: locked high 3 cycles then low -> ready stays 0 and loss_count stays 0.
REQ-032 SHALL verify lock loss: in RUN, drop locked for 1 cycle -> ready falls 3 cycles later, loss_count=1, re-qualifies after 8 stable cycles.
REQ-033 SHALL verify timeout: locked held 0 -> pll_resetb low for 4 cycles starting 32 cycles after reset; retry_count=1; repeats every 36 cycles.
REQ-034 SHALL verify saturation and clear: 260 lock losses -> loss_count=255; clear_stats coinciding with a loss -> loss_count=0.
REQ-035 SHALL verify reset mid-RUN: reset_n=0 -> sys_reset_n=0 without a clock edge; all counters read 0.
